// File: rtl/spi_pkg.sv
// SPI master shared types: opcodes, widths, FSM state encoding.
// Used by spi_master_ctrl and spi_master_shifter.
package spi_pkg;

  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_SHIFT,
    S_WAIT,
    S_READ,
    S_GAP
  } state_e;

endpackage

// File: rtl/spi_master_shifter.sv
// SPI master datapath: 10-bit MOSI shift-out, 8-bit MISO shift-in,
// and the shared saturating down-counter used by every FSM phase.
module spi_master_shifter
  import spi_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [FRAME_W-1:0] din,
  input  logic               shift_en,
  input  logic               sample_en,
  input  logic               miso,
  input  logic               cnt_ld,
  input  logic [3:0]         cnt_val,
  output logic               mosi_bit,
  output logic [3:0]         cnt,
  output logic [DATA_W-1:0]  sin_nxt
);

  logic [FRAME_W-1:0] sout_q, sout_d;
  logic [DATA_W-1:0]  sin_q, sin_d;
  logic [3:0]         cnt_q, cnt_d;

  assign mosi_bit = sout_q[FRAME_W-1];
  assign cnt      = cnt_q;
  assign sin_nxt  = {sin_q[DATA_W-2:0], miso};

  // next values: load/shift, sample, count down and hold at zero
  always_comb begin
    sout_d = sout_q;
    if (load)
      sout_d = din;
    else if (shift_en)
      sout_d = {sout_q[FRAME_W-2:0], 1'b0};
    sin_d = sample_en ? sin_nxt : sin_q;
    cnt_d = cnt_q;
    if (cnt_ld)
      cnt_d = cnt_val;
    else if (cnt_q != 4'd0)
      cnt_d = cnt_q - 4'd1;
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sout_q <= '0;
      sin_q  <= '0;
      cnt_q  <= '0;
    end else begin
      sout_q <= sout_d;
      sin_q  <= sin_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master controller: host handshake, frame FSM, read-byte return.
// Optional SPI_MASTER_ABORT_EN adds an abort input that cuts a frame to GAP.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int MISO_LAT   = 3,
  parameter int GAP_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef SPI_MASTER_ABORT_EN
  input  logic                abort,
`endif
  input  logic                cmd_valid,
  input  logic [FRAME_W-1:0]  cmd_data,
  output logic                cmd_ready,
  output logic                SS_n,
  output logic                MOSI,
  input  logic                MISO,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  output logic                busy
);

  localparam logic [3:0] LAT_LD = 4'(MISO_LAT - 1);
  localparam logic [3:0] GAP_LD = 4'(GAP_CYCLES - 1);

  state_e state_q, state_d;

  logic              abort_w;
  logic              xfer;
  logic              last;
  logic              active;
  logic              load, shift_en, sample_en;
  logic              cnt_ld;
  logic [3:0]        cnt_val, cnt;
  logic              mosi_bit;
  logic [DATA_W-1:0] sin_nxt;

  logic              op_rd_q, op_rd_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rdy_en_q, rdy_en_d;
  logic              done;

`ifdef SPI_MASTER_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign xfer   = cmd_valid && cmd_ready;
  assign last   = (cnt == 4'd0);
  assign active = (state_q == S_CMD) || (state_q == S_SHIFT) ||
                  (state_q == S_WAIT) || (state_q == S_READ);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (xfer) state_d = S_CMD;
      S_CMD:   state_d = S_SHIFT;
      S_SHIFT: if (last) state_d = op_rd_q ? S_WAIT : S_GAP;
      S_WAIT:  if (last) state_d = S_READ;
      S_READ:  if (last) state_d = S_GAP;
      S_GAP:   if (last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_w && active)
      state_d = S_GAP;
  end

  // outputs and datapath strobes; counter reloads on every state change
  always_comb begin
    SS_n      = 1'b1;
    MOSI      = 1'b0;
    busy      = (state_q != S_IDLE);
    cmd_ready = (state_q == S_IDLE) && rdy_en_q;
    load      = xfer;
    shift_en  = (state_q == S_SHIFT);
    sample_en = (state_q == S_READ);
    cnt_ld    = (state_d != state_q);
    unique case (state_q)
      S_CMD, S_SHIFT: begin
        SS_n = 1'b0;
        MOSI = mosi_bit;
      end
      S_WAIT, S_READ: SS_n = 1'b0;
      default: ;
    endcase
    unique case (state_d)
      S_SHIFT: cnt_val = 4'd9;
      S_WAIT:  cnt_val = LAT_LD;
      S_READ:  cnt_val = 4'd7;
      S_GAP:   cnt_val = GAP_LD;
      default: cnt_val = 4'd0;
    endcase
  end

  // read tracking: opcode latch, completed byte, one-cycle valid
  always_comb begin
    op_rd_d    = xfer ? (cmd_data[9:8] == OP_RD_DATA) : op_rd_q;
    done       = (state_q == S_READ) && last && !abort_w;
    rd_valid_d = done;
    rd_data_d  = done ? sin_nxt : rd_data_q;
    rdy_en_d   = 1'b1;
  end

  // read tracking registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_rd_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rdy_en_q   <= 1'b0;
    end else begin
      op_rd_q    <= op_rd_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rdy_en_q   <= rdy_en_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

  spi_master_shifter u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .din       (cmd_data),
    .shift_en  (shift_en),
    .sample_en (sample_en),
    .miso      (MISO),
    .cnt_ld    (cnt_ld),
    .cnt_val   (cnt_val),
    .mosi_bit  (mosi_bit),
    .cnt       (cnt),
    .sin_nxt   (sin_nxt)
  );

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl (MISO_LAT=3, GAP_CYCLES=1).
// Abort steps are built only when SPI_MASTER_ABORT_EN is defined.
module tb_spi_master_ctrl;

  localparam int LAT = 3;
  localparam int GAP = 1;
  localparam int RS  = 12 + LAT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [9:0] cmd_data;
  logic       cmd_ready;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       busy;
`ifdef SPI_MASTER_ABORT_EN
  logic       abort;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  spi_master_ctrl #(
    .MISO_LAT   (LAT),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef SPI_MASTER_ABORT_EN
    .abort     (abort),
`endif
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic start_cmd(input logic [9:0] c);
    cmd_data  = c;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_frame(input bit pulse, input logic [7:0] sb,
                           output int nlow, output logic [21:0] mo,
                           output int nrdv);
    nlow = 0;
    nrdv = 0;
    mo   = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rd_valid) nrdv++;
      if (!SS_n) begin
        nlow++;
        mo = {mo[20:0], MOSI};
        cmd_valid = pulse && (nlow == 12);
        if (nlow >= RS && nlow < RS + 8)
          MISO = sb[7 - (nlow - RS)];
        else
          MISO = 1'b0;
      end else if (nlow > 0) begin
        break;
      end
    end
    cmd_valid = 1'b0;
    MISO      = 1'b0;
  endtask

  int          nl, rv, lows0, lows1, gap, fr, rdy_bad, extra;
  logic [21:0] mo;
  logic [10:0] mo0, mo1;
  logic        prev;

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    MISO      = 1'b0;
`ifdef SPI_MASTER_ABORT_EN
    abort     = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_ss_n", 32'(SS_n), 32'd1);
    chk("rst_mosi", 32'(MOSI), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(cmd_ready), 32'd1);

    // write address 0x3A
    start_cmd(10'h03A);
    run_frame(1'b0, 8'h00, nl, mo, rv);
    chk("wr_len", 32'(nl), 32'd11);
    chk("wr_mosi", 32'(mo), 32'h03A);
    chk("wr_rdv", 32'(rv), 32'd0);
    chk("wr_rd_data", 32'(rd_data), 32'd0);

    // read data, slave returns 0xA5
    start_cmd(10'h300);
    run_frame(1'b0, 8'hA5, nl, mo, rv);
    chk("rd_len", 32'(nl), 32'd22);
    chk("rd_mosi", 32'(mo[21:11]), 32'h700);
    chk("rd_rdv", 32'(rv), 32'd1);
    chk("rd_data", 32'(rd_data), 32'hA5);
    @(negedge clk);
    chk("rd_valid_pulse", 32'(rd_valid), 32'd0);

    // cmd_valid pulse during WAIT is ignored
    start_cmd(10'h3FF);
    run_frame(1'b1, 8'h3C, nl, mo, rv);
    chk("ign_len", 32'(nl), 32'd22);
    chk("ign_rdv", 32'(rv), 32'd1);
    chk("ign_rd_data", 32'(rd_data), 32'h3C);
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (!SS_n) extra++;
    end
    chk("ign_no_frame", 32'(extra), 32'd0);

    // back-to-back: SS_n high for the GAP dwell plus the IDLE accept cycle
    start_cmd(10'h155);
    lows0 = 0; lows1 = 0; gap = 0; fr = -1; rdy_bad = 0;
    mo0 = '0; mo1 = '0; prev = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!SS_n) begin
        if (prev) begin
          fr++;
          if (fr == 0) cmd_data = 10'h012;
          if (fr == 1) cmd_valid = 1'b0;
        end
        if (fr == 0) begin
          lows0++;
          mo0 = {mo0[9:0], MOSI};
        end else begin
          lows1++;
          mo1 = {mo1[9:0], MOSI};
        end
        if (cmd_ready) rdy_bad++;
      end else if (fr == 0) begin
        gap++;
      end
      prev = SS_n;
      if (fr == 1 && SS_n) break;
    end
    cmd_valid = 1'b0;
    chk("b2b_frames", 32'(fr), 32'd1);
    chk("b2b_len0", 32'(lows0), 32'd11);
    chk("b2b_len1", 32'(lows1), 32'd11);
    chk("b2b_gap", 32'(gap), 32'(GAP + 1));
    chk("b2b_ready_low", 32'(rdy_bad), 32'd0);
    chk("b2b_mosi0", 32'(mo0), 32'h155);
    chk("b2b_mosi1", 32'(mo1), 32'h012);
    @(negedge clk);

    // reset in the middle of SHIFT
    start_cmd(10'h155);
    nl = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!SS_n) begin
        nl++;
        cmd_valid = 1'b0;
        if (nl == 6) break;
      end
    end
    chk("mid_reached", 32'(nl), 32'd6);
    rst_n = 1'b0;
    #1;
    chk("mid_ss_async", 32'(SS_n), 32'd1);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_rd_data", 32'(rd_data), 32'd0);
    @(negedge clk);
    chk("mid_ready_rst", 32'(cmd_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_ready", 32'(cmd_ready), 32'd1);
    chk("mid_ss_n", 32'(SS_n), 32'd1);
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (!SS_n) extra++;
    end
    chk("mid_no_frame", 32'(extra), 32'd0);

`ifdef SPI_MASTER_ABORT_EN
    // abort during READ bit 2
    start_cmd(10'h300);
    nl = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!SS_n) begin
        nl++;
        cmd_valid = 1'b0;
        MISO = 1'b1;
        if (nl == RS + 2) begin
          abort = 1'b1;
          break;
        end
      end
    end
    chk("ab_reached", 32'(nl), 32'(RS + 2));
    @(negedge clk);
    abort = 1'b0;
    MISO  = 1'b0;
    chk("ab_ss_n", 32'(SS_n), 32'd1);
    rv = int'(rd_valid);
    @(negedge clk);
    rv = rv + int'(rd_valid);
    chk("ab_ready", 32'(cmd_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      rv = rv + int'(rd_valid);
    end
    chk("ab_rdv", 32'(rv), 32'd0);
    chk("ab_rd_data", 32'(rd_data), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
